// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice and a registered carry,
// processing WIDTH-bit operands LSB first between two valid/ready handshakes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Returns {carry, sum} of a single full-adder slice.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    logic [1:0]       state_r, state_s;
    logic [WIDTH-1:0] a_r, a_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic [WIDTH-1:0] sum_r, sum_s;
    logic             carry_r, carry_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic             cout_r, cout_s;
    logic             ovf_r, ovf_s;
    logic [1:0]       slice_s;

    // Next-state and datapath logic for the three-state sequencer.
    always_comb begin
        state_s  = state_r;
        a_s      = a_r;
        b_s      = b_r;
        sum_s    = sum_r;
        carry_s  = carry_r;
        cnt_s    = cnt_r;
        result_s = result_r;
        cout_s   = cout_r;
        ovf_s    = ovf_r;
        slice_s  = full_add(a_r[0], b_r[0], carry_r);
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + ~cin, so the borrow-in is inverted too.
                    a_s     = a;
                    b_s     = sub ? ~b : b;
                    carry_s = sub ? ~cin : cin;
                    sum_s   = {WIDTH{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                a_s     = {1'b0, a_r[WIDTH-1:1]};
                b_s     = {1'b0, b_r[WIDTH-1:1]};
                sum_s   = {slice_s[0], sum_r[WIDTH-1:1]};
                carry_s = slice_s[1];
                cnt_s   = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    // carry_r here is the carry into the MSB slice.
                    result_s = {slice_s[0], sum_r[WIDTH-1:1]};
                    cout_s   = slice_s[1];
                    ovf_s    = carry_r ^ slice_s[1];
                    state_s  = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            sum_r    <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            a_r      <= a_s;
            b_r      <= b_s;
            sum_r    <= sum_s;
            carry_r  <= carry_s;
            cnt_r    <= cnt_s;
            result_r <= result_s;
            cout_r   <= cout_s;
            ovf_r    <= ovf_s;
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign result    = result_r;
    assign cout      = cout_r;
    assign overflow  = ovf_r;

endmodule
